// File: rtl/serial_in_parallel_out_receiver.sv
// rtl/serial_in_parallel_out_receiver.sv - serial-to-parallel word receiver with valid/ack handshake and sticky overrun
module serial_in_parallel_out_receiver #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Serial_Data_In,
  input  logic             Shift_Enable_In,
  input  logic             Frame_Start_In,
  input  logic             Data_Ack_In,
  output logic [WIDTH-1:0] Parallel_Data_Out,
  output logic             Data_Valid_Out,
  output logic             Overrun_Out,
  output logic             Busy_Out,
  output logic [WIDTH-1:0] SIPO_Shift_Register
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    cnt_eff;
  logic [WIDTH-1:0] shift_next;
  logic             word_done;

  // Frame start realigns the counter before the current bit is considered;
  // the new bit enters at the MSB (LSB-first stream) or the LSB (MSB-first).
  always_comb begin
    cnt_eff    = Frame_Start_In ? '0 : bit_cnt;
    shift_next = SIPO_Shift_Register;
    if (LSB_FIRST != 0) begin
      shift_next = {Serial_Data_In, SIPO_Shift_Register[WIDTH-1:1]};
    end else begin
      shift_next = {SIPO_Shift_Register[WIDTH-2:0], Serial_Data_In};
    end
    word_done = Shift_Enable_In && (cnt_eff == CNT_LAST);
  end

  // Shift register, framing counter, word capture and handshake state.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      SIPO_Shift_Register <= '0;
      Parallel_Data_Out   <= '0;
      bit_cnt             <= '0;
      Data_Valid_Out      <= 1'b0;
      Overrun_Out         <= 1'b0;
    end else begin
      if (Shift_Enable_In) begin
        SIPO_Shift_Register <= shift_next;
        bit_cnt             <= word_done ? '0 : cnt_eff + CW'(1);
      end else begin
        bit_cnt <= cnt_eff;
      end

      if (word_done) begin
        Parallel_Data_Out <= shift_next;
        Data_Valid_Out    <= 1'b1;
        // Overwriting a word nobody has taken yet; a same-edge ack consumes it.
        if (Data_Valid_Out && !Data_Ack_In) begin
          Overrun_Out <= 1'b1;
        end
      end else if (Data_Ack_In && Data_Valid_Out) begin
        Data_Valid_Out <= 1'b0;
      end
    end
  end

  // A partial word is held whenever the counter is off zero.
  always_comb begin
    Busy_Out = (bit_cnt != '0);
  end

endmodule

// File: tb/tb_serial_in_parallel_out_receiver.sv
// tb/tb_serial_in_parallel_out_receiver.sv - directed self-checking bench for serial_in_parallel_out_receiver
module tb_serial_in_parallel_out_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sd = 1'b0;
  logic       en = 1'b0;
  logic       fs = 1'b0;
  logic       ack = 1'b0;

  logic [7:0] l_data, l_sr, m_data, m_sr;
  logic       l_valid, l_ovr, l_busy, m_valid, m_ovr, m_busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_in_parallel_out_receiver #(.WIDTH(8), .LSB_FIRST(1)) dut (
    .Clk_In(clk), .Reset_In(rst), .Serial_Data_In(sd), .Shift_Enable_In(en),
    .Frame_Start_In(fs), .Data_Ack_In(ack), .Parallel_Data_Out(l_data),
    .Data_Valid_Out(l_valid), .Overrun_Out(l_ovr), .Busy_Out(l_busy),
    .SIPO_Shift_Register(l_sr)
  );

  serial_in_parallel_out_receiver #(.WIDTH(8), .LSB_FIRST(0)) dut_msb (
    .Clk_In(clk), .Reset_In(rst), .Serial_Data_In(sd), .Shift_Enable_In(en),
    .Frame_Start_In(fs), .Data_Ack_In(ack), .Parallel_Data_Out(m_data),
    .Data_Valid_Out(m_valid), .Overrun_Out(m_ovr), .Busy_Out(m_busy),
    .SIPO_Shift_Register(m_sr)
  );

  task automatic drive_bit(input logic b, input logic f, input logic a);
    @(negedge clk);
    sd = b; en = 1'b1; fs = f; ack = a;
    @(posedge clk);
    #1;
    en = 1'b0; fs = 1'b0; ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic msb_first);
    for (int i = 0; i < 8; i++) drive_bit(msb_first ? w[7-i] : w[i], 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({l_data, l_sr, l_valid, l_ovr, l_busy} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_lsb: got %h expected 0", {l_data, l_sr, l_valid, l_ovr, l_busy});
    end
    tests_run++;
    if ({m_data, m_sr, m_valid, m_ovr, m_busy} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_msb: got %h expected 0", {m_data, m_sr, m_valid, m_ovr, m_busy});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      drive_bit(w[i], 1'b0, 1'b0);
      tests_run++;
      if (l_busy !== (i < 7)) begin
        tests_failed++;
        $display("FAIL basic_busy_edge%0d: got %b expected %b", i + 1, l_busy, (i < 7));
      end
      if (i == 6) begin
        tests_run++;
        if (l_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL basic_early_valid: got %b expected 0", l_valid);
        end
      end
    end
    tests_run++;
    if (l_data !== 8'hA5 || l_valid !== 1'b1 || l_sr !== 8'hA5) begin
      tests_failed++;
      $display("FAIL basic_word: got data %h valid %b sr %h expected a5 1 a5", l_data, l_valid, l_sr);
    end
    pulse_ack();
    tests_run++;
    if (l_valid !== 1'b0 || l_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL basic_ack: got valid %b data %h expected 0 a5", l_valid, l_data);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 3));
      drive_bit(w[i], 1'b0, 1'b0);
    end
    tests_run++;
    if (l_data !== 8'hA5 || l_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL gaps_word: got data %h valid %b expected a5 1", l_data, l_valid);
    end
    idle(1);
    tests_run++;
    if (l_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL gaps_hold_valid: got %b expected 1", l_valid);
    end
    pulse_ack();
    tests_run++;
    if (l_valid !== 1'b0 || l_ovr !== 1'b0 || l_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL gaps_ack: got valid %b ovr %b data %h expected 0 0 a5", l_valid, l_ovr, l_data);
    end
  endtask

  task automatic test_frame_start();
    logic [7:0] w;
    w = 8'h3C;
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0, 1'b0);
    drive_bit(w[0], 1'b1, 1'b0);
    for (int i = 1; i < 7; i++) drive_bit(w[i], 1'b0, 1'b0);
    tests_run++;
    if (l_valid !== 1'b0 || l_data !== 8'hA5 || l_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL frame_before_last: got valid %b data %h busy %b expected 0 a5 1", l_valid, l_data, l_busy);
    end
    drive_bit(w[7], 1'b0, 1'b0);
    tests_run++;
    if (l_data !== 8'h3C || l_valid !== 1'b1 || l_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_word: got data %h valid %b busy %b expected 3c 1 0", l_data, l_valid, l_busy);
    end
    pulse_ack();
  endtask

  task automatic test_overrun();
    send_word(8'h11, 1'b0);
    tests_run++;
    if (l_ovr !== 1'b0 || l_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_first: got ovr %b valid %b expected 0 1", l_ovr, l_valid);
    end
    send_word(8'h22, 1'b0);
    tests_run++;
    if (l_data !== 8'h22 || l_valid !== 1'b1 || l_ovr !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_second: got data %h valid %b ovr %b expected 22 1 1", l_data, l_valid, l_ovr);
    end
    pulse_ack();
    tests_run++;
    if (l_valid !== 1'b0 || l_ovr !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_sticky: got valid %b ovr %b expected 0 1", l_valid, l_ovr);
    end
    do_reset();
    tests_run++;
    if (l_ovr !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovr_reset_clear: got %b expected 0", l_ovr);
    end
  endtask

  task automatic test_ack_on_complete();
    logic [7:0] w;
    w = 8'h5A;
    send_word(8'h11, 1'b0);
    for (int i = 0; i < 7; i++) drive_bit(w[i], 1'b0, 1'b0);
    drive_bit(w[7], 1'b0, 1'b1);
    tests_run++;
    if (l_data !== 8'h5A || l_valid !== 1'b1 || l_ovr !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_same_edge: got data %h valid %b ovr %b expected 5a 1 0", l_data, l_valid, l_ovr);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] w;
    w = 8'hF0;
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({l_data, l_sr, l_valid, l_ovr, l_busy} !== 19'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got %h expected 0", {l_data, l_sr, l_valid, l_ovr, l_busy});
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({l_sr, l_busy, l_valid} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_edge_ignored: got %h expected 0", {l_sr, l_busy, l_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) drive_bit(w[i], 1'b0, 1'b0);
    tests_run++;
    if (l_data !== 8'hF0 || l_valid !== 1'b1 || l_ovr !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset_word: got data %h valid %b ovr %b expected f0 1 0", l_data, l_valid, l_ovr);
    end
  endtask

  task automatic test_msb_first();
    do_reset();
    send_word(8'hA5, 1'b1);
    tests_run++;
    if (m_data !== 8'hA5 || m_valid !== 1'b1 || m_sr !== 8'hA5) begin
      tests_failed++;
      $display("FAIL msb_a5: got data %h valid %b sr %h expected a5 1 a5", m_data, m_valid, m_sr);
    end
    pulse_ack();
    send_word(8'h1E, 1'b1);
    tests_run++;
    if (m_data !== 8'h1E || m_valid !== 1'b1 || m_ovr !== 1'b0) begin
      tests_failed++;
      $display("FAIL msb_1e: got data %h valid %b ovr %b expected 1e 1 0", m_data, m_valid, m_ovr);
    end
    tests_run++;
    if (l_data !== 8'h78) begin
      tests_failed++;
      $display("FAIL lsb_view_of_1e: got %h expected 78", l_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_frame_start();
    test_overrun();
    test_ack_on_complete();
    test_async_reset();
    test_msb_first();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
